// File: rtl/f8_pkg.sv
// Shared widths, FSM state type and address helper for the f8 instruction-fetch path.
package f8_pkg;

    localparam int ADDR_W      = 16;
    localparam int IFETCH_W    = 24;
    localparam int WIN_W       = 32;
    localparam int FETCH_BYTES = IFETCH_W / 8;
    localparam int WIN_BYTES   = WIN_W / 8;

    typedef enum logic [1:0] {
        IFQ_IDLE,
        IFQ_WAIT,
        IFQ_DROP
    } ifq_state_t;

    // Address following a completed 3-byte fetch; wraps mod 2^16.
    function automatic logic [ADDR_W-1:0] next_fetch_addr(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(FETCH_BYTES);
    endfunction

endpackage

// File: rtl/byte_ring.sv
// DEPTH-byte circular buffer: 3-byte write port at tail, 4-byte read window at head.
module byte_ring
    import f8_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [IFETCH_W-1:0] wr_data,
    input  logic [2:0]          rd_cnt,
    output logic [WIN_W-1:0]    window,
    output logic [CW-1:0]       count
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            head    <= tail;
            count_q <= '0;
        end else begin
            head    <= head + PW'(rd_cnt);
            if (wr_en) begin
                tail <= tail + PW'(FETCH_BYTES);
            end
            count_q <= count_q - CW'(rd_cnt) + (wr_en ? CW'(FETCH_BYTES) : '0);
        end
    end

    // NOTE: storage is not reset; occupancy lives in count_q and stale slots are masked below.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                mem[tail + PW'(k)] <= wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: default first so every bit is assigned on every path and no latch is inferred.
        window = '0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            if (CW'(k) < count_q) begin
                window[8*k +: 8] = mem[head + PW'(k)];
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch byte queue: issues 24-bit fetches and feeds a 4-byte window to the decoder.
module ifetch_queue
    import f8_pkg::*;
#(
    parameter int                DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   iread_addr,
    input  logic [IFETCH_W-1:0] iread_data,
    input  logic                iread_valid,
    output logic [WIN_W-1:0]    ibytes,
    output logic [3:0]          ibytes_avail,
    output logic [ADDR_W-1:0]   ipc,
    input  logic [2:0]          consume,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ifq_state_t        state;
    ifq_state_t        state_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     left;
    logic [CW-1:0]     free;
    logic [2:0]        take;
    logic              accept;

    // Decoder may not retire more than the window width or more than is queued.
    always_comb begin
        take = (consume > 3'd4) ? 3'd4 : consume;
        if (CW'(take) > count) begin
            take = count[2:0];
        end
    end

    always_comb begin
        left = count - CW'(take);
        free = CW'(DEPTH) - left;
    end

    assign accept = (state == IFQ_WAIT) && iread_valid && !redirect;

    // A response lands behind the bytes left after this cycle's consume, so staying in
    // WAIT needs room for this response plus the next one.
    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = (state == IFQ_IDLE) ? IFQ_IDLE : IFQ_DROP;
        end else begin
            case (state)
                IFQ_IDLE: begin
                    if (free >= CW'(FETCH_BYTES)) begin
                        state_next = IFQ_WAIT;
                    end
                end
                IFQ_WAIT: begin
                    if (iread_valid) begin
                        state_next = (free >= CW'(2 * FETCH_BYTES)) ? IFQ_WAIT : IFQ_IDLE;
                    end
                end
                IFQ_DROP: begin
                    if (iread_valid) begin
                        state_next = IFQ_IDLE;
                    end
                end
                default: state_next = IFQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IFQ_IDLE;
            fetch_addr <= RESET_PC;
            ipc        <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect) begin
                fetch_addr <= redirect_pc;
                ipc        <= redirect_pc;
            end else begin
                if (accept) begin
                    fetch_addr <= next_fetch_addr(fetch_addr);
                end
                ipc <= ipc + ADDR_W'(take);
            end
        end
    end

    byte_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect),
        .wr_en   (accept),
        .wr_data (iread_data),
        .rd_cnt  (redirect ? 3'd0 : take),
        .window  (ibytes),
        .count   (count)
    );

    assign iread_addr   = fetch_addr;
    assign ibytes_avail = 4'(count);

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: expected byte stream queued from each restart address,
// popped as the decoder model consumes, plus directed timing checks.
module tb_ifetch_queue;
    import f8_pkg::*;

    localparam int          DEPTH    = 8;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] iread_addr;
    logic [23:0] iread_data;
    logic        iread_valid;
    logic [31:0] ibytes;
    logic [3:0]  ibytes_avail;
    logic [15:0] ipc;
    logic [2:0]  consume;
    logic        redirect;
    logic [15:0] redirect_pc;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .iread_addr   (iread_addr),
        .iread_data   (iread_data),
        .iread_valid  (iread_valid),
        .ibytes       (ibytes),
        .ibytes_avail (ibytes_avail),
        .ipc          (ipc),
        .consume      (consume),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mem_en;
    logic [7:0]  sb_q[$];
    logic [15:0] sb_fill;
    logic [15:0] exp_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Memory contents: mem[a] = a[7:0] + 7*a[15:8] (mod 256); 0x00..0x0F at 0x0000.
    function automatic logic [7:0] mb(input logic [15:0] a);
        logic [15:0] p;
        p = 16'(a[15:8]) * 16'd7;
        return a[7:0] + p[7:0];
    endfunction

    task automatic sb_top();
        while (sb_q.size() < 16) begin
            sb_q.push_back(mb(sb_fill));
            sb_fill = sb_fill + 16'd1;
        end
    endtask

    task automatic sb_restart(input logic [15:0] pc);
        sb_q.delete();
        sb_fill = pc;
        exp_pc  = pc;
        sb_top();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem();
        iread_valid = mem_en;
        iread_data  = {mb(iread_addr + 16'd2), mb(iread_addr + 16'd1), mb(iread_addr)};
    endtask

    task automatic observe();
        int n;
        check("avail_bound", {31'b0, (ibytes_avail <= 4'(DEPTH))}, 32'd1);
        check("ipc", ipc, exp_pc);
        n = (ibytes_avail > 4'd4) ? 4 : int'(ibytes_avail);
        for (int i = 0; i < n; i++) begin
            check($sformatf("win[%0d]", i), ibytes[8*i +: 8], sb_q[i]);
        end
    endtask

    task automatic do_consume(input int want);
        int k;
        k = (want > int'(ibytes_avail)) ? int'(ibytes_avail) : want;
        for (int i = 0; i < k; i++) void'(sb_q.pop_front());
        exp_pc  = exp_pc + 16'(k);
        consume = 3'(k);
        sb_top();
    endtask

    task automatic cycle(input int want);
        observe();
        do_consume(want);
        redirect = 1'b0;
        drive_mem();
        tick();
    endtask

    task automatic redir(input logic [15:0] pc, input int cons);
        redirect    = 1'b1;
        redirect_pc = pc;
        consume     = 3'(cons);
        drive_mem();
        tick();
        redirect = 1'b0;
        consume  = 3'd0;
        sb_restart(pc);
    endtask

    task automatic wait_fill(input string tag);
        int t;
        t = 0;
        while (ibytes_avail == 4'd0 && t < 10) begin
            cycle(0);
            t++;
        end
        check(tag, ibytes_avail, 32'd3);
    endtask

    initial begin
        int exp_avail[7];
        int exp_addr[7];
        exp_avail = '{0, 0, 3, 6, 6, 6, 6};
        exp_addr  = '{0, 0, 3, 6, 6, 6, 6};

        reset       = 1'b1;
        consume     = 3'd0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        iread_valid = 1'b0;
        iread_data  = 24'h0;
        mem_en      = 1'b1;
        sb_restart(RESET_PC);

        // Reset state
        #2;
        check("rst_avail", ibytes_avail, 32'd0);
        check("rst_ibytes", ibytes, 32'h0);
        check("rst_ipc", ipc, RESET_PC);
        check("rst_addr", iread_addr, RESET_PC);
        tick();
        tick();
        reset = 1'b0;

        // Idle decoder: two fetches then stall at 6 bytes
        for (int j = 0; j < 7; j++) begin
            check($sformatf("fill_avail[%0d]", j), ibytes_avail, exp_avail[j]);
            check($sformatf("fill_addr[%0d]", j), iread_addr, exp_addr[j]);
            cycle(0);
        end
        check("fill_ibytes", ibytes, 32'h03020100);
        check("fill_ipc", ipc, 32'h0);

        // Steady consume=3: one fetch per cycle, no bubbles
        for (int j = 0; j < 12; j++) begin
            if (j >= 1) check($sformatf("steady_avail[%0d]", j), ibytes_avail, 32'd3);
            check($sformatf("steady_addr[%0d]", j), iread_addr, (j == 0) ? 6 : 6 + 3 * (j - 1));
            cycle(3);
        end

        // Redirect while in WAIT: in-flight response must be dropped
        mem_en = 1'b0;
        redir(16'h1234, 0);
        check("redir_avail", ibytes_avail, 32'd0);
        check("redir_ipc", ipc, 32'h1234);
        check("redir_addr", iread_addr, 32'h1234);
        iread_valid = 1'b1;
        iread_data  = 24'hDEADBE;
        tick();
        check("drop_avail", ibytes_avail, 32'd0);
        mem_en = 1'b1;
        check("refetch_addr", iread_addr, 32'h1234);
        drive_mem();
        tick();
        check("refetch_avail0", ibytes_avail, 32'd0);
        drive_mem();
        tick();
        check("refetch_avail", ibytes_avail, 32'd3);
        check("refetch_head", ibytes[7:0], mb(16'h1234));
        check("refetch_ipc", ipc, 32'h1234);
        for (int j = 0; j < 6; j++) cycle(2);

        // Redirect together with consume=2: consume ignored
        check("pre_redir_avail", {31'b0, (ibytes_avail >= 4'd2)}, 32'd1);
        redir(16'h0100, 2);
        check("redir2_avail", ibytes_avail, 32'd0);
        check("redir2_ipc", ipc, 32'h0100);
        for (int j = 0; j < 12; j++) cycle(1);

        // Redirect to 0xFFFE: fetch wraps the address space
        redir(16'hFFFE, 0);
        wait_fill("wrap_fill");
        check("wrap_fetch_addr", iread_addr, 32'h0001);
        check("wrap_bytes", ibytes[23:0], {mb(16'h0000), mb(16'hFFFF), mb(16'hFFFE)});
        check("wrap_ipc", ipc, 32'hFFFE);
        for (int j = 0; j < 10; j++) cycle(1);

        // Reset for one cycle mid-WAIT, stray response afterwards
        redir(16'h0040, 0);
        wait_fill("pre_reset_fill");
        reset = 1'b1;
        #1;
        check("midrst_avail", ibytes_avail, 32'd0);
        check("midrst_ipc", ipc, RESET_PC);
        check("midrst_addr", iread_addr, RESET_PC);
        tick();
        reset = 1'b0;
        sb_restart(RESET_PC);
        iread_valid = 1'b1;
        iread_data  = 24'hDEADBE;
        consume     = 3'd0;
        tick();
        check("stray_avail", ibytes_avail, 32'd0);
        check("stray_ipc", ipc, RESET_PC);
        cycle(0);
        check("postrst_avail", ibytes_avail, 32'd3);
        check("postrst_head", ibytes[7:0], mb(RESET_PC));

        // Random consume, memory stalls and occasional redirects
        for (int j = 0; j < 300; j++) begin
            if ($urandom_range(0, 31) == 0) begin
                mem_en = 1'b1;
                redir(16'($urandom), int'($urandom_range(0, 4)));
            end else begin
                mem_en = ($urandom_range(0, 3) != 0);
                cycle(int'($urandom_range(0, 4)));
            end
        end
        cycle(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
